sd_block_read_ctrl: RTL and testbench
=====================================

Name: sd_block_read_ctrl

Overview:
Sequences one SPI-mode single-block read (CMD17) on the SD bus once card initialisation has completed. It frames and shifts out CMD17, waits for and checks the R1 response, hunts for the 0xFE data start token, and deserialises the data block into bytes for the downstream FIFO. It then discards the CRC and reports done or error. It runs entirely in the SCLK domain, alongside the init sequencer, which owns MOSI while this block is idle.

Parameters:
BLOCK_BYTES, 512, data bytes per block
ADDR_SHIFT, 0, left shift applied to rd_addr (0 = SDHC block addressing, 9 = SDSC byte addressing)
R1_TIMEOUT, 80, max SCLK cycles waiting for the R1 start bit
TOKEN_TIMEOUT, 4096, max SCLK cycles waiting for the 0xFE token
GAP_BITS, 8, trailing MOSI-high clocks after each transaction

Ports:
SCLK  in  1  SD serial clock; all state changes on posedge
reset_PB_down  in  1  asynchronous active-high reset
init_done  in  1  card initialised; read requests accepted only while high
rd_req  in  1  single-cycle read request
rd_addr  in  32  block address, latched on accept
MISO  in  1  card data out, sampled on posedge SCLK
MOSI  out  1  card data in
busy  out  1  transaction in progress
fifo_data_in  out  8  assembled data byte
fifo_push  out  1  one-cycle push strobe
fifo_full  in  1  downstream FIFO full
done  out  1  one-cycle pulse: block read without error
error  out  1  one-cycle pulse: transaction aborted or overrun
err_code  out  3  0 none, 1 R1 timeout, 2 R1 nonzero, 3 token timeout, 4 FIFO overrun
r1_status  out  8  last R1 byte received

Behaviour:
- Reset (async, any state): state IDLE, MOSI=1, busy=0, fifo_push=0, fifo_data_in=0, done=0, error=0, err_code=0, r1_status=0, all counters 0.
- States: IDLE, SEND_CMD, WAIT_R1, GET_R1, WAIT_TOKEN, GET_DATA, SKIP_CRC, GAP, FIN.
- IDLE: if rd_req && init_done:
  - latch frame = {8'h51, rd_addr<<ADDR_SHIFT (truncated to 32), 8'hFF}
  - clear err_code and overrun flag
  - go to SEND_CMD; busy=1 from the next cycle
  - rd_req while busy, or while init_done=0, is ignored (no queueing).
- SEND_CMD: 48 cycles; MOSI = frame bit 47 down to 0, MSB first; then WAIT_R1. MOSI=1 in every other state.
- WAIT_R1: sample MISO each cycle.
  - MISO=0: this is R1 bit 7; go to GET_R1 with bit count 1.
  - After R1_TIMEOUT cycles with no 0 sampled: err_code=1, go to GAP.
- GET_R1: shift in 7 more bits, MSB first, and load r1_status.
  - R1 == 8'h00: go to WAIT_TOKEN.
  - Otherwise: err_code=2, go to GAP.
- WAIT_TOKEN: 8-bit sliding window of MISO (newest bit in LSB).
  - Window == 8'hFE (on the cycle the last bit is sampled): go to GET_DATA with byte and bit counters 0.
  - Window not matched after TOKEN_TIMEOUT cycles: err_code=3, go to GAP.
  - Token search is bit-granular; byte alignment relative to the command is not required.
- GET_DATA: shift MISO MSB first. On the 8th bit:
  - the next cycle registers fifo_data_in = byte and pulses fifo_push for exactly one cycle, provided fifo_full=0 at the 8th-bit sample.
  - If fifo_full=1 at that sample, the byte is dropped with no push and the overrun flag is set; reading continues (SCLK cannot be stalled).
  - After BLOCK_BYTES bytes, go to SKIP_CRC.
  - Push spacing is exactly 8 cycles; the last push lands in the first SKIP_CRC cycle.
- SKIP_CRC: 16 cycles with MOSI=1; the CRC is not checked. Then go to GAP.
- GAP: GAP_BITS cycles with MOSI=1, then FIN.
- FIN: one cycle, then IDLE with busy=0 on the following cycle.
  - If err_code!=0, or the overrun flag is set (err_code becomes 4 when it was 0): error=1.
  - Otherwise: done=1.
  - done and error are never both high.
- err_code and r1_status hold their values until the next accepted request.
- init_done falling mid-transaction is ignored; the transaction runs to FIN.
- Reset mid-transaction aborts immediately with no done or error pulse.

Test Plan:
- rd_addr=0x0000_0010, ADDR_SHIFT=0, card model returns R1=0x00 after 3 high bits, token after 20 cycles, bytes 0x00..0xFF twice -> MOSI carries 0x51_00000010_FF; 512 pushes in ascending order; done pulse; err_code=0.
- ADDR_SHIFT=9, rd_addr=0x3 -> address field 0x0000_0600 on MOSI.
- MISO held high after the command -> error pulse after 80 WAIT_R1 cycles, err_code=1, no pushes.
- R1=0x04 -> r1_status=0x04, err_code=2, error pulse, no pushes.
- R1 ok, token never sent -> err_code=3 after 4096 cycles.
- fifo_full=1 during byte 100 -> 511 pushes, byte 100 missing, error pulse, err_code=4.
- reset_PB_down asserted mid-GET_DATA -> MOSI=1 and busy=0 immediately; a new rd_req is then accepted normally.
- rd_req pulsed while busy -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/sd_block_read_ctrl_if.sv
// Request, status, SPI data and FIFO-side signals of the SD single-block reader.
interface sd_block_read_ctrl_if;
    logic        init_done;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        MISO;
    logic        MOSI;
    logic        busy;
    logic [7:0]  fifo_data_in;
    logic        fifo_push;
    logic        fifo_full;
    logic        done;
    logic        error;
    logic [2:0]  err_code;
    logic [7:0]  r1_status;

    modport master (
        output init_done, rd_req, rd_addr, MISO, fifo_full,
        input  MOSI, busy, fifo_data_in, fifo_push, done, error, err_code, r1_status
    );

    modport slave (
        input  init_done, rd_req, rd_addr, MISO, fifo_full,
        output MOSI, busy, fifo_data_in, fifo_push, done, error, err_code, r1_status
    );
endinterface

// File: rtl/sd_block_read_ctrl.sv
// SPI-mode CMD17 single-block read sequencer: frames the command, checks R1, hunts the
// 0xFE start token, deserialises the block into FIFO pushes and reports done or error.
module sd_block_read_ctrl #(
    parameter int BLOCK_BYTES   = 512,
    parameter int ADDR_SHIFT    = 0,
    parameter int R1_TIMEOUT    = 80,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int GAP_BITS      = 8
) (
    input logic                 SCLK,
    input logic                 reset_PB_down,
    sd_block_read_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, WAIT_R1, GET_R1, WAIT_TOKEN, GET_DATA, SKIP_CRC, GAP, FIN
    } state_t;

    localparam int WAIT_MAX = (TOKEN_TIMEOUT > R1_TIMEOUT) ? TOKEN_TIMEOUT : R1_TIMEOUT;
    localparam int CNT_MAX  = (WAIT_MAX > GAP_BITS) ? WAIT_MAX : GAP_BITS;
    localparam int CNT_W    = $clog2(CNT_MAX + 64);
    localparam int BYTE_W   = $clog2(BLOCK_BYTES + 1);

    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(47);
    localparam logic [CNT_W-1:0]  R1_LAST    = CNT_W'(R1_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  TOKEN_LAST = CNT_W'(TOKEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CRC_LAST   = CNT_W'(15);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_BITS - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(BLOCK_BYTES - 1);

    state_t              state_q, state_d;
    logic [47:0]         frame_q, frame_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          data_q, data_d;
    logic                push_q, push_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [2:0]          err_q, err_d;
    logic [7:0]          r1_q, r1_d;
    logic [7:0]          sample;
    logic [31:0]         addr_shifted;

    // One shift register serves as R1 assembler, token window and data byte in turn.
    assign sample       = {shift_q[6:0], bus.MISO};
    assign addr_shifted = bus.rd_addr << ADDR_SHIFT;

    assign bus.MOSI         = (state_q == SEND_CMD) ? frame_q[47] : 1'b1;
    assign bus.busy         = (state_q != IDLE);
    assign bus.fifo_data_in = data_q;
    assign bus.fifo_push    = push_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.err_code     = err_q;
    assign bus.r1_status    = r1_q;

    always_ff @(posedge SCLK or posedge reset_PB_down) begin
        if (reset_PB_down) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            overrun_q  <= 1'b0;
            data_q     <= '0;
            push_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= '0;
            r1_q       <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            overrun_q  <= overrun_d;
            data_q     <= data_d;
            push_q     <= push_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_q      <= err_d;
            r1_q       <= r1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        overrun_d  = overrun_q;
        data_d     = data_q;
        push_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_d      = err_q;
        r1_d       = r1_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rd_req && bus.init_done) begin
                    frame_d   = {8'h51, addr_shifted, 8'hFF};
                    err_d     = 3'd0;
                    overrun_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SEND_CMD;
                end
            end
            SEND_CMD: begin
                frame_d = {frame_q[46:0], 1'b1};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CMD_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_R1;
                end
            end
            WAIT_R1: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!bus.MISO) begin
                    shift_d   = 8'h00;
                    bit_cnt_d = 3'd1;
                    state_d   = GET_R1;
                end else if (cnt_q == R1_LAST) begin
                    err_d   = 3'd1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GET_R1: begin
                shift_d   = sample;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    r1_d    = sample;
                    cnt_d   = '0;
                    shift_d = 8'h00;
                    if (sample == 8'h00) begin
                        state_d = WAIT_TOKEN;
                    end else begin
                        err_d   = 3'd2;
                        state_d = GAP;
                    end
                end
            end
            WAIT_TOKEN: begin
                shift_d = sample;
                cnt_d   = cnt_q + CNT_W'(1);
                if (sample == 8'hFE) begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = GET_DATA;
                end else if (cnt_q == TOKEN_LAST) begin
                    err_d   = 3'd3;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GET_DATA: begin
                shift_d   = sample;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    // SCLK cannot be held, so a full FIFO costs the byte rather than stalling.
                    if (bus.fifo_full) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_d = sample;
                        push_d = 1'b1;
                    end
                    byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    if (byte_cnt_q == BYTE_LAST) begin
                        cnt_d   = '0;
                        state_d = SKIP_CRC;
                    end
                end
            end
            SKIP_CRC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CRC_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end
            end
            FIN: begin
                if (err_q != 3'd0 || overrun_q) begin
                    error_d = 1'b1;
                    if (err_q == 3'd0) err_d = 3'd4;
                end else begin
                    done_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sd_block_read_ctrl.sv
// Randomised scoreboard bench: a card model replays scripted MISO streams while expected
// pushes and completions are queued per request and checked by an independent monitor.
module tb_sd_block_read_ctrl;
    localparam int BLOCK  = 512;
    localparam int GAP    = 8;
    localparam int R1_TO  = 80;
    localparam int TOK_TO = 4096;

    typedef struct { logic [7:0] data; int cyc; } push_t;
    typedef struct { bit is_err; logic [2:0] code; logic [7:0] r1; int cyc; } end_t;

    logic SCLK = 1'b0;
    logic reset_PB_down = 1'b1;

    sd_block_read_ctrl_if bus ();
    sd_block_read_ctrl_if bus9 ();

    sd_block_read_ctrl dut (.SCLK(SCLK), .reset_PB_down(reset_PB_down), .bus(bus.slave));
    sd_block_read_ctrl #(.ADDR_SHIFT(9)) dut9 (.SCLK(SCLK), .reset_PB_down(reset_PB_down), .bus(bus9.slave));

    assign bus9.init_done = bus.init_done;
    assign bus9.rd_req    = bus.rd_req;
    assign bus9.rd_addr   = bus.rd_addr;
    assign bus9.MISO      = 1'b1;
    assign bus9.fifo_full = 1'b0;

    always #5 SCLK = ~SCLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int push_seen = 0;
    logic [31:0] cur_addr = '0;
    logic [7:0] last_r1 = '0;
    push_t exp_push_q[$];
    end_t exp_end_q[$];
    logic [1:0] resp_q[$];
    push_t pe;
    end_t ee;
    int cmd_n = 0;
    logic [47:0] cmd_cap = '0;
    int cap9_n = 0;
    logic [47:0] cap9 = '0;

    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Card model: captures the command off MOSI, then plays {fifo_full, MISO} pairs.
    always @(negedge SCLK) begin
        if (!bus.busy) begin
            cmd_n = 0;
            bus.MISO = 1'b1;
            bus.fifo_full = 1'b0;
        end else if (cmd_n < 48) begin
            cmd_cap = {cmd_cap[46:0], bus.MOSI};
            cmd_n++;
            if (cmd_n == 48) checkOutput("cmd_frame", cmd_cap, {8'h51, cur_addr, 8'hFF});
        end else begin
            checkOutput("mosi_high_after_cmd", bus.MOSI, 1);
            if (resp_q.size() > 0) {bus.fifo_full, bus.MISO} = resp_q.pop_front();
            else {bus.fifo_full, bus.MISO} = 2'b01;
        end
    end

    always @(negedge SCLK) begin
        if (!bus9.busy) begin
            cap9_n = 0;
        end else if (cap9_n < 48) begin
            cap9 = {cap9[46:0], bus9.MOSI};
            cap9_n++;
            if (cap9_n == 48) checkOutput("cmd_frame_shift9", cap9, {8'h51, cur_addr * 32'd512, 8'hFF});
        end
    end

    always @(negedge SCLK) begin
        if (bus.fifo_push) begin
            push_seen++;
            if (exp_push_q.size() == 0) begin
                checkOutput("unexpected_push", 1, 0);
            end else begin
                pe = exp_push_q.pop_front();
                checkOutput("push_data", bus.fifo_data_in, pe.data);
                checkOutput("push_cycle", cyc - accept_cyc, pe.cyc);
            end
        end
        if (bus.done || bus.error) begin
            if (exp_end_q.size() == 0) begin
                checkOutput("unexpected_end", 1, 0);
            end else begin
                ee = exp_end_q.pop_front();
                checkOutput("end_done", bus.done, !ee.is_err);
                checkOutput("end_error", bus.error, ee.is_err);
                checkOutput("end_err_code", bus.err_code, ee.code);
                checkOutput("end_r1_status", bus.r1_status, ee.r1);
                checkOutput("end_cycle", cyc - accept_cyc, ee.cyc);
                checkOutput("end_busy", bus.busy, 0);
            end
        end
    end

    // kind: 0 data block, 1 no R1, 2 R1=0x04, 3 no token; drop >= 0 marks a full-FIFO byte.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input int pre,
                                 input int gap, input int drop, input bit ramp);
        logic [7:0] r1;
        logic [7:0] b;
        logic [7:0] tok;
        end_t e;
        int t_tok;
        resp_q.delete();
        exp_push_q.delete();
        exp_end_q.delete();
        push_seen = 0;
        cur_addr = addr;
        tok = 8'hFE;
        r1 = (kind == 2) ? 8'h04 : 8'h00;
        if (kind != 1) begin
            repeat (pre) resp_q.push_back(2'b01);
            for (int i = 7; i >= 0; i--) resp_q.push_back({1'b0, r1[i]});
            last_r1 = r1;
        end
        e.r1 = last_r1;
        if (kind == 0) begin
            repeat (gap) resp_q.push_back(2'b01);
            for (int i = 7; i >= 0; i--) resp_q.push_back({1'b0, tok[i]});
            t_tok = 49 + pre + 8 + gap + 7;
            for (int k = 0; k < BLOCK; k++) begin
                b = ramp ? 8'(k) : 8'($urandom);
                for (int i = 7; i >= 0; i--) resp_q.push_back({(k == drop), b[i]});
                if (k != drop) exp_push_q.push_back('{data: b, cyc: t_tok + 8 * (k + 1)});
            end
            repeat (16) resp_q.push_back({1'b0, 1'($urandom)});
            e.is_err = (drop >= 0);
            e.code   = (drop >= 0) ? 3'd4 : 3'd0;
            e.cyc    = t_tok + 8 * BLOCK + 16 + GAP + 1;
        end else if (kind == 1) begin
            e.is_err = 1'b1; e.code = 3'd1; e.cyc = 48 + R1_TO + GAP + 1;
        end else if (kind == 2) begin
            e.is_err = 1'b1; e.code = 3'd2; e.cyc = 49 + pre + 7 + GAP + 1;
        end else begin
            e.is_err = 1'b1; e.code = 3'd3; e.cyc = 49 + pre + 8 + (TOK_TO - 1) + GAP + 1;
        end
        exp_end_q.push_back(e);
        @(negedge SCLK);
        bus.rd_addr = addr;
        bus.rd_req = 1'b1;
        @(negedge SCLK);
        bus.rd_req = 1'b0;
        accept_cyc = cyc;
    endtask

    task automatic waitForEnd(input int budget);
        int n = 0;
        while (exp_end_q.size() != 0 && n < budget) begin
            @(negedge SCLK);
            n++;
        end
        checkOutput("end_within_budget", exp_end_q.size(), 0);
        checkOutput("all_pushes_seen", exp_push_q.size(), 0);
        repeat (3) @(negedge SCLK);
    endtask

    initial begin
        int n;
        bus.init_done = 1'b1;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        repeat (3) @(negedge SCLK);
        checkOutput("reset_mosi", bus.MOSI, 1);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_push", bus.fifo_push, 0);
        checkOutput("reset_data", bus.fifo_data_in, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_error", bus.error, 0);
        checkOutput("reset_err_code", bus.err_code, 0);
        checkOutput("reset_r1", bus.r1_status, 0);
        reset_PB_down = 1'b0;
        repeat (2) @(negedge SCLK);

        bus.init_done = 1'b0;
        bus.rd_req = 1'b1;
        @(negedge SCLK);
        bus.rd_req = 1'b0;
        repeat (4) @(negedge SCLK);
        checkOutput("no_accept_without_init", bus.busy, 0);
        bus.init_done = 1'b1;

        applyStimulus(0, 32'h0000_0010, 3, 12, -1, 1'b1);
        waitForEnd(6000);
        applyStimulus(0, $urandom, $urandom_range(0, 20), $urandom_range(0, 40), -1, 1'b0);
        waitForEnd(6000);
        applyStimulus(1, 32'h0000_0003, 0, 0, -1, 1'b0);
        waitForEnd(400);
        applyStimulus(2, $urandom, $urandom_range(0, 20), 0, -1, 1'b0);
        waitForEnd(400);
        applyStimulus(3, $urandom, $urandom_range(0, 20), 0, -1, 1'b0);
        waitForEnd(6000);
        applyStimulus(0, $urandom, $urandom_range(0, 20), $urandom_range(0, 40), 100, 1'b0);
        waitForEnd(6000);

        applyStimulus(0, $urandom, 2, 5, -1, 1'b0);
        n = 0;
        while (push_seen < 40 && n < 2000) begin
            @(negedge SCLK);
            n++;
        end
        checkOutput("reached_mid_data", push_seen >= 40, 1);
        #2 reset_PB_down = 1'b1;
        #1;
        checkOutput("abort_mosi", bus.MOSI, 1);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_push", bus.fifo_push, 0);
        exp_push_q.delete();
        exp_end_q.delete();
        last_r1 = 8'h00;
        @(negedge SCLK);
        reset_PB_down = 1'b0;
        checkOutput("abort_err_code", bus.err_code, 0);
        checkOutput("abort_r1", bus.r1_status, 0);
        repeat (3) @(negedge SCLK);
        applyStimulus(0, $urandom, $urandom_range(0, 20), $urandom_range(0, 40), -1, 1'b0);
        waitForEnd(6000);

        applyStimulus(0, $urandom, $urandom_range(0, 20), $urandom_range(0, 40), -1, 1'b0);
        repeat (30) @(negedge SCLK);
        bus.rd_req = 1'b1;
        @(negedge SCLK);
        bus.rd_req = 1'b0;
        bus.init_done = 1'b0;
        repeat (500) @(negedge SCLK);
        bus.init_done = 1'b1;
        bus.rd_req = 1'b1;
        @(negedge SCLK);
        bus.rd_req = 1'b0;
        waitForEnd(6000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
